// File: rtl/riscv_defs.sv
// Shared RISC-V front-end definitions: the NOP encoding, the default reset
// PC and the fetch FSM state encoding.
package riscv_defs;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE     = 2'd0,  // free to issue a request
    FETCH_WAIT_RSP = 2'd1,  // one request outstanding, response wanted
    FETCH_DROP     = 2'd2   // one request outstanding, response unwanted
  } fetch_state_e;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer that parks a fetched instruction while decode is
// stalled. Clear wins over push; push wins over pop, so a same-cycle
// push/pop replaces the entry and keeps it valid.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  // Entry valid flag and payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      pc_q    <= 32'h0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (push_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps PCF, issues at most one request to the
// instruction memory, squashes responses made stale by a redirect, and
// feeds the IF/ID register through a one-entry skid buffer.
module fetch_unit
  import riscv_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  addr_q;
  logic         valid_d_q;
  logic [31:0]  instr_d_q, pc_d_q, pc_plus4_d_q;

  logic         skid_valid;
  logic [31:0]  skid_instr, skid_pc;
  logic         fire, deliver, skid_push, skid_pop;

  // Request only when idle, fetch not stalled and nothing parked; the rst
  // term keeps the request low for the whole reset pulse.
  assign imem_req  = (state_q == FETCH_IDLE) & ~StallF & ~skid_valid & ~rst;
  assign imem_addr = pcf_q;
  assign fire      = imem_req & imem_gnt;
  // A response is useful only if it is for the live path.
  assign deliver   = (state_q == FETCH_WAIT_RSP) & imem_rvalid & ~PCSrcE;
  // Park the response if decode is stalled, or if the skid entry is moving
  // into IF/ID this cycle (the second case is kept unreachable by imem_req).
  assign skid_push = deliver & (StallD | skid_valid);
  assign skid_pop  = ~FlushD & ~StallD & skid_valid;

  // Next state and next PC; a redirect overrides the +4 step.
  always_comb begin
    state_d = state_q;
    pcf_d   = pcf_q;
    case (state_q)
      FETCH_IDLE:     if (fire) state_d = PCSrcE ? FETCH_DROP : FETCH_WAIT_RSP;
      FETCH_WAIT_RSP: begin
        if (imem_rvalid) state_d = FETCH_IDLE;
        else if (PCSrcE) state_d = FETCH_DROP;
      end
      FETCH_DROP:     if (imem_rvalid) state_d = FETCH_IDLE;
      default:        state_d = FETCH_IDLE;
    endcase
    if (PCSrcE)    pcf_d = PCTargetE;
    else if (fire) pcf_d = pc_plus4(pcf_q);
  end

  // FSM state, fetch PC and the address of the outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_IDLE;
      pcf_q   <= RESET_PC;
      addr_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      if (fire) addr_q <= pcf_q;
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .clear_i (PCSrcE),
    .instr_i (imem_rdata),
    .pc_i    (addr_q),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  // IF/ID register: flush, hold, skid entry first, then the fresh response,
  // otherwise a bubble. A bubble keeps the previous PC fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_d_q    <= 1'b0;
      instr_d_q    <= NOP_INSTR;
      pc_d_q       <= 32'h0;
      pc_plus4_d_q <= 32'h4;
    end else if (FlushD) begin
      valid_d_q <= 1'b0;
      instr_d_q <= NOP_INSTR;
    end else if (!StallD) begin
      if (skid_valid) begin
        valid_d_q    <= 1'b1;
        instr_d_q    <= skid_instr;
        pc_d_q       <= skid_pc;
        pc_plus4_d_q <= pc_plus4(skid_pc);
      end else if (deliver) begin
        valid_d_q    <= 1'b1;
        instr_d_q    <= imem_rdata;
        pc_d_q       <= addr_q;
        pc_plus4_d_q <= pc_plus4(addr_q);
      end else begin
        valid_d_q <= 1'b0;
        instr_d_q <= NOP_INSTR;
      end
    end
  end

  assign ValidD   = valid_d_q;
  assign InstrD   = instr_d_q;
  assign PCD      = pc_d_q;
  assign PCPlus4D = pc_plus4_d_q;

  // A response must never arrive while the skid entry is still occupied.
  a_no_skid_overrun: assert property (@(posedge clk) disable iff (rst)
    !(deliver && skid_valid));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level reference
// model, plus a second instance fetching across the 32-bit address wrap.
module tb_fetch_unit;
  import riscv_defs::*;

  localparam logic [31:0] HI_PC = 32'hFFFF_FFF8;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  logic        hi_req, hi_rvalid, hi_ValidD;
  logic [31:0] hi_addr, hi_raddr, hi_rdata, hi_InstrD, hi_PCD, hi_PCPlus4D;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD)
  );

  fetch_unit #(.RESET_PC(HI_PC)) u_dut_hi (
    .clk(clk), .rst(rst), .StallF(1'b0), .StallD(1'b0), .FlushD(1'b0),
    .PCSrcE(1'b0), .PCTargetE(32'h0), .imem_req(hi_req),
    .imem_addr(hi_addr), .imem_gnt(1'b1), .imem_rvalid(hi_rvalid),
    .imem_rdata(hi_rdata), .InstrD(hi_InstrD), .PCD(hi_PCD),
    .PCPlus4D(hi_PCPlus4D), .ValidD(hi_ValidD)
  );

  // Program contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Zero-wait memory for the wrap-around instance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_rvalid <= 1'b0;
      hi_raddr  <= 32'h0;
    end else begin
      hi_rvalid <= hi_req;
      hi_raddr  <= hi_addr;
    end
  end
  assign hi_rdata = mem_word(hi_raddr);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: next PC, one optional outstanding fetch (with a
  // "killed" mark when a redirect overtook it), a parked-instruction queue
  // and the IF/ID contents.
  bit          m_busy, m_killed, m_vld;
  logic [31:0] m_opc, m_pc;
  ent_t        m_skid[$];
  ent_t        m_ifid;

  task automatic m_reset();
    m_busy = 0; m_killed = 0; m_vld = 0;
    m_opc = 32'h0; m_pc = RESET_PC_DEFAULT;
    m_skid.delete();
    m_ifid = {NOP_INSTR, 32'h0};
  endtask

  function automatic bit m_req();
    return !rst && !m_busy && !StallF && (m_skid.size() == 0);
  endfunction

  // Advance the model across one clock edge using the current inputs.
  task automatic m_step();
    bit   req, have, parked;
    ent_t d;
    req = m_req();
    have = 0;
    parked = (m_skid.size() != 0);
    d = '0;
    if (m_busy && imem_rvalid) begin
      if (!m_killed && !PCSrcE) begin
        have = 1;
        d = {imem_rdata, m_opc};
      end
      m_busy = 0;
    end else if (m_busy && PCSrcE) begin
      m_killed = 1;
    end
    if (req && imem_gnt) begin
      m_busy = 1;
      m_opc = m_pc;
      m_killed = PCSrcE;
    end
    if (PCSrcE) m_pc = PCTargetE;
    else if (req && imem_gnt) m_pc = m_pc + 32'd4;
    if (FlushD) begin
      m_vld = 0;
      m_ifid.instr = NOP_INSTR;
    end else if (!StallD) begin
      if (parked) begin
        m_ifid = m_skid.pop_front();
        m_vld = 1;
      end else if (have) begin
        m_ifid = d;
        m_vld = 1;
        have = 0;
      end else begin
        m_vld = 0;
        m_ifid.instr = NOP_INSTR;
      end
    end
    if (have && (StallD || parked)) m_skid.push_back(d);
    if (PCSrcE) m_skid.delete();
  endtask

  // Bench-side memory: one response per grant after a 0..2 cycle wait.
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          cyc_no;
  bit          collect;
  logic [31:0] v_pcd[$];
  int          v_cyc[$];
  logic [31:0] hi_addrs[$], hi_pcd[$], hi_p4[$], hi_ins[$];

  task automatic drive(input bit rnd);
    StallF    = rnd && ($urandom_range(0, 99) < 15);
    StallD    = rnd && ($urandom_range(0, 99) < 25);
    FlushD    = rnd && ($urandom_range(0, 99) < 6);
    PCSrcE    = rnd && ($urandom_range(0, 99) < 7);
    PCTargetE = $urandom() & 32'hFFFF_FFFC;
    imem_gnt  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (mem_busy && mem_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom();
    end
  endtask

  // One clock: check the request side before the edge, advance the model,
  // then check IF/ID after the edge. Inputs must already be applied.
  task automatic tick(input bit rnd);
    bit          req_s, gnt_s, rv_s;
    logic [31:0] a_s;
    #1;
    chk("imem_req", {31'h0, imem_req}, {31'h0, m_req()});
    chk("imem_addr", imem_addr, m_pc);
    req_s = imem_req; gnt_s = imem_gnt; rv_s = imem_rvalid; a_s = imem_addr;
    if (collect && hi_req) hi_addrs.push_back(hi_addr);
    m_step();
    if (mem_busy && rv_s) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (req_s && gnt_s) begin
      mem_busy = 1;
      mem_addr = a_s;
      mem_cnt  = rnd ? int'($urandom_range(0, 2)) : 0;
    end
    @(posedge clk);
    #1;
    cyc_no++;
    chk("ValidD", {31'h0, ValidD}, {31'h0, m_vld});
    chk("InstrD", InstrD, m_ifid.instr);
    if (m_vld) begin
      chk("PCD", PCD, m_ifid.pc);
      chk("PCPlus4D", PCPlus4D, m_ifid.pc + 32'd4);
    end
    if (collect && ValidD) begin
      v_pcd.push_back(PCD);
      v_cyc.push_back(cyc_no);
    end
    if (collect && hi_ValidD) begin
      hi_pcd.push_back(hi_PCD);
      hi_p4.push_back(hi_PCPlus4D);
      hi_ins.push_back(hi_InstrD);
    end
  endtask

  task automatic cyc(input bit rnd);
    @(negedge clk);
    drive(rnd);
    tick(rnd);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ValidD"}, {31'h0, ValidD}, 32'h0);
    chk({tag, "_InstrD"}, InstrD, NOP_INSTR);
    chk({tag, "_PCD"}, PCD, 32'h0);
    chk({tag, "_PCPlus4D"}, PCPlus4D, 32'h4);
    chk({tag, "_req"}, {31'h0, imem_req}, 32'h0);
    chk({tag, "_addr"}, imem_addr, RESET_PC_DEFAULT);
  endtask

  initial begin
    rst = 1'b1;
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 32'h0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'h0;
    mem_busy = 0; mem_addr = 32'h0; mem_cnt = 0; cyc_no = 0; collect = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait memory, no hazards.
    collect = 1;
    drive(0);
    tick(0);
    repeat (7) cyc(0);
    collect = 0;
    chk("seq_count", (v_pcd.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
    if (v_pcd.size() >= 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("seq_pcd%0d", i), v_pcd[i], 32'(4 * i));
      chk("seq_gap01", 32'(v_cyc[1] - v_cyc[0]), 32'd2);
      chk("seq_gap12", 32'(v_cyc[2] - v_cyc[1]), 32'd2);
    end
    chk("hi_count", (hi_addrs.size() >= 3 && hi_pcd.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
    if (hi_addrs.size() >= 3 && hi_pcd.size() >= 3) begin
      chk("hi_addr0", hi_addrs[0], 32'hFFFF_FFF8);
      chk("hi_addr1", hi_addrs[1], 32'hFFFF_FFFC);
      chk("hi_addr2", hi_addrs[2], 32'h0000_0000);
      chk("hi_instr0", hi_ins[0], mem_word(32'hFFFF_FFF8));
      chk("hi_p4_0", hi_p4[0], 32'hFFFF_FFFC);
      chk("hi_pcd1", hi_pcd[1], 32'hFFFF_FFFC);
      chk("hi_p4_1", hi_p4[1], 32'h0000_0000);
      chk("hi_pcd2", hi_pcd[2], 32'h0000_0000);
    end

    // Random hazards, redirects and memory timing.
    repeat (3000) cyc(1);

    // Get a request outstanding, then reset mid-wait.
    for (int i = 0; i < 12; i++) begin
      cyc(0);
      if (m_busy) break;
    end
    chk("mid_wait_reached", {31'h0, m_busy}, 32'h1);
    @(negedge clk);
    drive(0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    m_reset();
    mem_busy = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Stray response with nothing outstanding must be ignored.
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0;
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    tick(0);
    repeat (6) cyc(0);
    repeat (500) cyc(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC fetched first after reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 StallF  input  1  hazard-unit stall of fetch; no new memory request while high.
REQ-005 StallD  input  1  hazard-unit stall of decode; IF/ID register holds while high.
REQ-006 FlushD  input  1  hazard-unit flush of decode; IF/ID register becomes a bubble.
REQ-007 PCSrcE  input  1  taken branch or jump in execute; redirect fetch.
REQ-008 PCTargetE  input  32  redirect target; valid when PCSrcE=1.
REQ-009 imem_req  output  1  instruction-memory request.
REQ-010 imem_addr  output  32  request address; equals PCF.
REQ-011 imem_gnt  input  1  request accepted this cycle.
REQ-012 imem_rvalid  input  1  response data valid this cycle.
REQ-013 imem_rdata  input  32  response instruction word.
REQ-014 InstrD, PCD, PCPlus4D  output  32 each  IF/ID register contents.
REQ-015 ValidD  output  1  IF/ID register holds a real instruction; 0 means bubble.

Function
REQ-016 FSM states: IDLE, WAIT_RSP, DROP; at most one request outstanding.
REQ-017 imem_req = (state==IDLE) & !StallF & !skid_full; combinational from state and inputs.
REQ-018 While imem_req=1 and imem_gnt=0, imem_addr may change only through a redirect (retargeting is legal before grant).
REQ-019 IDLE with req & gnt: capture PCF into addr_q, PCF <= PCF+4, go to WAIT_RSP; if PCSrcE=1 in the same cycle, go to DROP and PCF <= PCTargetE.
REQ-020 WAIT_RSP with rvalid: deliver the response (REQ-023), go to IDLE; if PCSrcE=1 in the same cycle, discard the response, go to IDLE.
REQ-021 WAIT_RSP with PCSrcE and no rvalid: go to DROP; DROP with rvalid: discard, go to IDLE.
REQ-022 Any PCSrcE=1 sets PCF <= PCTargetE and clears the skid buffer; redirect has priority over StallF and the +4 increment.
REQ-023 Delivered response = {imem_rdata, addr_q}; it loads IF/ID if StallD=0, else the 1-entry skid buffer.
REQ-024 IF/ID update priority: FlushD -> ValidD=0, InstrD=32'h0000_0013 (NOP); else StallD -> hold; else skid valid -> load skid, clear skid; else delivered response -> load; else ValidD=0 and InstrD=NOP.
REQ-025 When skid is full and a new response arrives, IF/ID loads the skid entry and the new response enters the skid buffer; REQ-017 keeps this unreachable, and an assertion shall flag it.
REQ-026 PCPlus4D = PCD+4, modulo 2^32; PCF wraps from 32'hFFFF_FFFC to 0.
REQ-027 Latency: gnt at cycle N and rvalid at N+1 put InstrD valid after the edge ending N+1; throughput is at most one instruction per 2 cycles.

Reset
REQ-028 Asserting rst immediately sets: state IDLE, PCF=RESET_PC, skid empty, ValidD=0, InstrD=NOP, PCD=0, PCPlus4D=4, addr_q=0.
REQ-029 imem_req is 0 while rst=1; a response arriving after rst deasserts with no request outstanding is ignored.

Structure
REQ-030 The shared riscv_defs package/header holds the NOP encoding, the RESET_PC default and the fetch FSM state encodings.
REQ-031 The skid buffer is sub-module fetch_skid_buf (1 entry: valid, instr, pc; push, pop, clear).

Verification
REQ-032 Zero-wait memory (gnt with req, rvalid next cycle), program at 0x0: PCD sequence 0,4,8 on alternate cycles with ValidD=1.
REQ-033 StallD=1 when rvalid arrives for 0x8: IF/ID holds 0x4, skid takes 0x8, imem_req=0; StallD released -> PCD=0x8 next edge.
REQ-034 PCSrcE=1, PCTargetE=0x100 while in WAIT_RSP: the next rvalid is discarded, imem_addr=0x100, no ValidD for the old PC.
REQ-035 PCSrcE coincident with gnt in IDLE: state DROP, next request address 0x100, stale data never reaches InstrD.
REQ-036 rst pulse mid-WAIT_RSP: outputs return to reset values that same cycle; first post-reset imem_addr=RESET_PC.
REQ-037 RESET_PC=32'hFFFF_FFF8: fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; PCPlus4D wraps correctly.
